cond_issue_unit: RTL and testbench

COND_ISSUE_UNIT -- requirements
Module: cond_issue_unit

---
 rtl/cond_pkg.sv | 47 ++++
 rtl/cond_issue_unit_if.sv | 58 +++++
 rtl/cond_eval.sv | 50 +++++
 rtl/cond_issue_unit.sv | 171 +++++++++++++++++
 tb/tb_cond_issue_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cond_pkg.sv
// ============================================================================
// Module      : cond_pkg
// Description : Shared types for the conditional issue unit. Holds the ARM
//               condition-code encoding, NZCV bit positions inside a 4-bit
//               flag word, and the deferred-flag tracker states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cond_pkg;

    // ARM condition field encodings, EQ = 4'b0000 through NV = 4'b1111.
    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_t;

    // Bit positions inside a {N,Z,C,V} flag word.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // IDLE: flag register is complete.
    // PENDING: a multi-cycle unit still owes the groups in pend_mask.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cond_issue_unit_if.sv
// ============================================================================
// Module      : cond_issue_unit_if
// Description : Bundle-level bus of the conditional issue unit.
//               master : issue/decode side (drives the bundle, sees results)
//               slave  : cond_issue_unit
//               Inputs : valid_e, cond_e, pcsrc_e, branch_e, regwrite_e,
//                        memwrite_e, nowrite_e, flagwrite_e, defer_e,
//                        alu_flags, late_valid, late_flags, flush
//               Outputs: pcsrc_out, regwrite_out, memwrite_out, condex_out,
//                        stall_out, flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cond_issue_unit_if #(
    parameter int LANES   = 2,
    parameter int FGROUPS = 2
);
    logic [LANES-1:0]              valid_e;
    logic [LANES-1:0][3:0]         cond_e;
    logic [LANES-1:0]              pcsrc_e;
    logic [LANES-1:0]              branch_e;
    logic [LANES-1:0]              regwrite_e;
    logic [LANES-1:0]              memwrite_e;
    logic [LANES-1:0]              nowrite_e;
    logic [LANES-1:0][FGROUPS-1:0] flagwrite_e;
    logic [LANES-1:0]              defer_e;
    logic [LANES-1:0][3:0]         alu_flags;
    logic                          late_valid;
    logic [3:0]                    late_flags;
    logic                          flush;

    logic [LANES-1:0]              pcsrc_out;
    logic [LANES-1:0]              regwrite_out;
    logic [LANES-1:0]              memwrite_out;
    logic [LANES-1:0]              condex_out;
    logic                          stall_out;
    logic [3:0]                    flags;

    modport master (
        output valid_e, cond_e, pcsrc_e, branch_e, regwrite_e, memwrite_e,
               nowrite_e, flagwrite_e, defer_e, alu_flags, late_valid,
               late_flags, flush,
        input  pcsrc_out, regwrite_out, memwrite_out, condex_out, stall_out,
               flags
    );

    modport slave (
        input  valid_e, cond_e, pcsrc_e, branch_e, regwrite_e, memwrite_e,
               nowrite_e, flagwrite_e, defer_e, alu_flags, late_valid,
               late_flags, flush,
        output pcsrc_out, regwrite_out, memwrite_out, condex_out, stall_out,
               flags
    );

endinterface

`default_nettype wire

// File: rtl/cond_eval.sv
// ============================================================================
// Module      : cond_eval
// Description : Evaluates one ARM condition field against a {N,Z,C,V} word.
//               cond  : 4-bit condition field
//               flags : 4-bit {N,Z,C,V}
//               pass  : 1 when the instruction may execute (NV never passes)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = flags[FLAG_N];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond_t'(cond))
            COND_EQ: pass = w_z;
            COND_NE: pass = ~w_z;
            COND_CS: pass = w_c;
            COND_CC: pass = ~w_c;
            COND_MI: pass = w_n;
            COND_PL: pass = ~w_n;
            COND_VS: pass = w_v;
            COND_VC: pass = ~w_v;
            COND_HI: pass = w_c & ~w_z;
            COND_LS: pass = ~w_c | w_z;
            COND_GE: pass = (w_n == w_v);
            COND_LT: pass = (w_n != w_v);
            COND_GT: pass = ~w_z & (w_n == w_v);
            COND_LE: pass = w_z | (w_n != w_v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cond_issue_unit.sv
// ============================================================================
// Module      : cond_issue_unit
// Description : Conditional-execution gate for a LANES-wide execute bundle.
//               Evaluates each lane against flags forwarded from older lanes
//               of the same bundle, squashes lanes younger than a taken
//               branch, owns the NZCV register and tracks one outstanding
//               multi-cycle flag result (stalling dependents until it lands).
//               clk   : rising-edge clock
//               reset : asynchronous active-low reset
//               bus   : cond_issue_unit_if.slave (bundle in, gated controls,
//                       stall_out and architectural flags out)
//               FGROUPS must divide 4. Group g owns flag bits
//               [g*(4/FGROUPS) +: 4/FGROUPS] (for 2 groups: g0=CV, g1=NZ).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_issue_unit
    import cond_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int FGROUPS = 2
) (
    input  logic            clk,
    input  logic            reset,
    cond_issue_unit_if.slave bus
);

    localparam int GW = 4 / FGROUPS;

    // Replace the flag bits belonging to the groups set in mask.
    function automatic logic [3:0] merge(input logic [3:0]         old_f,
                                         input logic [3:0]         new_f,
                                         input logic [FGROUPS-1:0] mask);
        logic [3:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b] = mask[b / GW] ? new_f[b] : old_f[b];
        end
        return r;
    endfunction

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_flags, w_flags_nxt;
    logic [FGROUPS-1:0] r_pend_mask, w_pend_mask_nxt;

    logic               w_late_hit;   // pending result returns this cycle
    logic               w_waiting;    // still pending after this cycle
    logic [3:0]         w_base;       // flags seen by lane 0
    logic               w_stall;
    logic [3:0]         w_fwd_last;
    logic [FGROUPS-1:0] w_defer_last;

    logic [LANES-1:0]   w_condex, w_pcsrc, w_regwrite, w_memwrite;

    assign w_late_hit = (r_state == PENDING) && bus.late_valid;
    assign w_waiting  = (r_state == PENDING) && !bus.late_valid;

    // The late result is bypassed so the bundle can issue in its arrival cycle.
    assign w_base = w_late_hit ? merge(r_flags, bus.late_flags, r_pend_mask)
                               : r_flags;

    // Only unconditional, non-flag-writing bundles may pass an open result.
    always_comb begin
        w_stall = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (bus.valid_e[i] &&
                ((bus.cond_e[i] != COND_AL) || (|bus.flagwrite_e[i]))) begin
                w_stall = 1'b1;
            end
        end
        w_stall = w_stall & w_waiting;
    end

    // Per-lane chain: each stage hands forwarded flags, the branch squash and
    // the mask of groups deferred by older lanes to the next younger lane.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [3:0]         f_in, f_out;
        logic               sq_in, sq_out;
        logic [FGROUPS-1:0] dm_in, dm_out;
        logic               pass, blocked, ex, redirect;

        if (i == 0) begin : g_head
            assign f_in  = w_base;
            assign sq_in = 1'b0;
            assign dm_in = '0;
        end else begin : g_chain
            assign f_in  = g_lane[i-1].f_out;
            assign sq_in = g_lane[i-1].sq_out;
            assign dm_in = g_lane[i-1].dm_out;
        end

        cond_eval u_eval (
            .cond  (bus.cond_e[i]),
            .flags (f_in),
            .pass  (pass)
        );

        // Behind a deferred flag write, a lane cannot know its condition nor
        // order its own flag write, so only plain AL lanes survive.
        assign blocked  = sq_in ||
                          ((|dm_in) && ((bus.cond_e[i] != COND_AL) ||
                                        (|bus.flagwrite_e[i])));
        assign ex       = bus.valid_e[i] & pass & ~blocked & ~bus.flush & ~w_stall;
        assign redirect = bus.pcsrc_e[i] | bus.branch_e[i];

        assign w_condex[i]   = ex;
        assign w_pcsrc[i]    = ex & redirect;
        assign w_regwrite[i] = ex & bus.regwrite_e[i] & ~bus.nowrite_e[i];
        assign w_memwrite[i] = ex & bus.memwrite_e[i];

        assign sq_out = sq_in | (ex & redirect);
        assign f_out  = (ex && !bus.defer_e[i])
                      ? merge(f_in, bus.alu_flags[i], bus.flagwrite_e[i]) : f_in;
        assign dm_out = dm_in | ((ex && bus.defer_e[i]) ? bus.flagwrite_e[i]
                                                        : {FGROUPS{1'b0}});
    end

    assign w_fwd_last   = g_lane[LANES-1].f_out;
    assign w_defer_last = g_lane[LANES-1].dm_out;

    assign bus.condex_out   = w_condex;
    assign bus.pcsrc_out    = w_pcsrc;
    assign bus.regwrite_out = w_regwrite;
    assign bus.memwrite_out = w_memwrite;
    assign bus.stall_out    = w_stall;
    assign bus.flags        = r_flags;

    always_comb begin
        w_state_nxt     = r_state;
        w_pend_mask_nxt = r_pend_mask;
        w_flags_nxt     = w_fwd_last;
        case (r_state)
            IDLE: begin
                if (|w_defer_last) begin
                    w_state_nxt     = PENDING;
                    w_pend_mask_nxt = w_defer_last;
                end
            end
            PENDING: begin
                if (bus.late_valid) begin
                    // The released bundle may itself start a new deferral.
                    if (|w_defer_last) begin
                        w_pend_mask_nxt = w_defer_last;
                    end else begin
                        w_state_nxt     = IDLE;
                        w_pend_mask_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_pend_mask_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_flags     <= 4'b0000;
            r_pend_mask <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flags     <= w_flags_nxt;
            r_pend_mask <= w_pend_mask_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cond_issue_unit.sv
// ============================================================================
// Module      : tb_cond_issue_unit
// Description : Self-checking bench for cond_issue_unit. Directed scenarios
//               followed by randomized bundles, all compared against an
//               architectural model of the flag register and the single
//               outstanding deferred flag result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_issue_unit;

    localparam int LANES   = 2;
    localparam int FGROUPS = 2;
    localparam int GW      = 4 / FGROUPS;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cond_issue_unit_if #(.LANES(LANES), .FGROUPS(FGROUPS)) bus ();

    cond_issue_unit #(.LANES(LANES), .FGROUPS(FGROUPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stimulus for the current bundle
    bit [3:0]         s_cond  [LANES];
    bit [FGROUPS-1:0] s_fw    [LANES];
    bit [3:0]         s_alu   [LANES];
    bit [LANES-1:0]   s_valid, s_pcsrc, s_branch, s_regw, s_memw, s_nowr, s_defer;
    bit               s_late_valid, s_flush;
    bit [3:0]         s_late;

    // Architectural model state
    bit [3:0]         m_flags;
    bit               m_pend;
    bit [FGROUPS-1:0] m_mask;

    // Model predictions for the current bundle
    bit [LANES-1:0]   e_condex, e_pcsrc, e_regw, e_memw;
    bit               e_stall;
    bit [3:0]         e_flags_nxt;
    bit               e_pend_nxt;
    bit [FGROUPS-1:0] e_mask_nxt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // ARM condition meanings written out from the architecture manual.
    function automatic bit arm_cond(input int c, input bit [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            0:  return z == 1;
            1:  return z == 0;
            2:  return cy == 1;
            3:  return cy == 0;
            4:  return n == 1;
            5:  return n == 0;
            6:  return v == 1;
            7:  return v == 0;
            8:  return cy == 1 && z == 0;
            9:  return cy == 0 || z == 1;
            10: return n == v;
            11: return n != v;
            12: return z == 0 && n == v;
            13: return z == 1 || n != v;
            14: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit [3:0] write_groups(input bit [3:0] old_f, input bit [3:0] new_f,
                                              input bit [FGROUPS-1:0] groups);
        bit [3:0] r;
        r = old_f;
        for (int b = 0; b < 4; b++) if (groups[b / GW]) r[b] = new_f[b];
        return r;
    endfunction

    task automatic model_eval();
        bit [3:0]         f;
        bit               resolved, waiting, taken, run;
        bit [FGROUPS-1:0] owed;
        resolved = m_pend && s_late_valid;
        waiting  = m_pend && !s_late_valid;
        f = resolved ? write_groups(m_flags, s_late, m_mask) : m_flags;
        e_stall = 0;
        if (waiting)
            for (int i = 0; i < LANES; i++)
                if (s_valid[i] && (s_cond[i] != 14 || s_fw[i] != 0)) e_stall = 1;
        e_condex = 0; e_pcsrc = 0; e_regw = 0; e_memw = 0;
        taken = 0; owed = 0;
        for (int i = 0; i < LANES; i++) begin
            run = s_valid[i] && arm_cond(s_cond[i], f) && !taken && !s_flush && !e_stall
                  && !(owed != 0 && (s_cond[i] != 14 || s_fw[i] != 0));
            if (run) begin
                e_condex[i] = 1;
                e_pcsrc[i]  = s_pcsrc[i] | s_branch[i];
                e_regw[i]   = s_regw[i] & ~s_nowr[i];
                e_memw[i]   = s_memw[i];
                if (e_pcsrc[i]) taken = 1;
                if (s_defer[i]) owed |= s_fw[i];
                else            f = write_groups(f, s_alu[i], s_fw[i]);
            end
        end
        e_flags_nxt = f;
        e_pend_nxt  = m_pend;
        e_mask_nxt  = m_mask;
        if (owed != 0) begin
            e_pend_nxt = 1; e_mask_nxt = owed;
        end else if (resolved) begin
            e_pend_nxt = 0; e_mask_nxt = 0;
        end
    endtask

    task automatic clr();
        for (int i = 0; i < LANES; i++) begin
            s_cond[i] = 4'd14; s_fw[i] = '0; s_alu[i] = '0;
        end
        s_valid = 0; s_pcsrc = 0; s_branch = 0; s_regw = 0; s_memw = 0;
        s_nowr = 0; s_defer = 0; s_late_valid = 0; s_flush = 0; s_late = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < LANES; i++) begin
            bus.cond_e[i]      = s_cond[i];
            bus.flagwrite_e[i] = s_fw[i];
            bus.alu_flags[i]   = s_alu[i];
        end
        bus.valid_e = s_valid; bus.pcsrc_e = s_pcsrc; bus.branch_e = s_branch;
        bus.regwrite_e = s_regw; bus.memwrite_e = s_memw; bus.nowrite_e = s_nowr;
        bus.defer_e = s_defer; bus.late_valid = s_late_valid;
        bus.late_flags = s_late; bus.flush = s_flush;
    endtask

    // Drive the bundle and compare combinational outputs at the falling edge.
    task automatic step_begin();
        drive();
        model_eval();
        @(negedge clk);
        chk("condex_out",   8'(bus.condex_out),   8'(e_condex));
        chk("pcsrc_out",    8'(bus.pcsrc_out),    8'(e_pcsrc));
        chk("regwrite_out", 8'(bus.regwrite_out), 8'(e_regw));
        chk("memwrite_out", 8'(bus.memwrite_out), 8'(e_memw));
        chk("stall_out",    8'(bus.stall_out),    8'(e_stall));
        chk("flags",        8'(bus.flags),        8'(m_flags));
    endtask

    task automatic step_end();
        @(posedge clk);
        m_flags = e_flags_nxt; m_pend = e_pend_nxt; m_mask = e_mask_nxt;
        #1;
    endtask

    task automatic step();
        step_begin();
        step_end();
    endtask

    task automatic model_reset();
        m_flags = 0; m_pend = 0; m_mask = 0;
    endtask

    initial begin
        clr();
        drive();
        model_reset();
        reset = 1'b0;
        #2;
        chk("reset_flags", 8'(bus.flags), 8'h0);
        chk("reset_stall", 8'(bus.stall_out), 8'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // SUBS sets Z in lane 0, BEQ in lane 1 sees it in the same cycle
        clr();
        s_valid = 2'b11;
        s_cond[0] = 4'd14; s_fw[0] = 2'b11; s_alu[0] = 4'b0100; s_regw[0] = 1;
        s_cond[1] = 4'd0;  s_branch[1] = 1;
        step_begin();
        chk("fwd_beq_taken", 8'(bus.pcsrc_out[1]), 8'h1);
        step_end();

        // Taken branch in lane 0 squashes a younger AL ADD with flag write
        clr();
        s_valid = 2'b11;
        s_branch[0] = 1;
        s_regw[1] = 1; s_fw[1] = 2'b11; s_alu[1] = 4'b1111;
        step_begin();
        chk("flags_after_subs", 8'(bus.flags), 8'b0100);
        chk("squash_regwrite", 8'(bus.regwrite_out[1]), 8'h0);
        step_end();

        // MULS defers its flags; BNE stalls until the late result lands
        clr();
        s_valid = 2'b01; s_defer[0] = 1; s_fw[0] = 2'b11; s_regw[0] = 1;
        step();
        clr();
        s_valid = 2'b01; s_cond[0] = 4'd1; s_branch[0] = 1;
        step_begin();
        chk("pending_stall", 8'(bus.stall_out), 8'h1);
        step_end();
        s_late_valid = 1; s_late = 4'b0100;
        step_begin();
        chk("late_unstall", 8'(bus.stall_out), 8'h0);
        chk("late_bne_nt", 8'(bus.pcsrc_out[0]), 8'h0);
        step_end();

        // Unconditional non-flag work proceeds under a pending result
        clr();
        s_valid = 2'b01; s_defer[0] = 1; s_fw[0] = 2'b10;
        step();
        clr();
        s_valid = 2'b11; s_regw = 2'b11;
        step_begin();
        chk("pending_al_regw", 8'(bus.regwrite_out), 8'b11);
        step_end();

        // Flush during PENDING still takes late_flags, blocks the CMP
        clr();
        s_valid = 2'b01; s_fw[0] = 2'b11; s_alu[0] = 4'b1000; s_flush = 1;
        s_late_valid = 1; s_late = 4'b1010;
        step();
        // Same flush in IDLE leaves flags untouched
        s_late_valid = 0;
        step();
        chk("flush_flags", 8'(bus.flags), 8'b1000);

        // Asynchronous reset in PENDING, then a stray late result
        clr();
        s_valid = 2'b01; s_defer[0] = 1; s_fw[0] = 2'b11;
        step();
        clr();
        s_valid = 2'b01; s_cond[0] = 4'd1;
        drive();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("midreset_flags", 8'(bus.flags), 8'h0);
        chk("midreset_stall", 8'(bus.stall_out), 8'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        clr();
        s_late_valid = 1; s_late = 4'b1111;
        step();
        clr();
        step();

        // Randomized bundles
        for (int n = 0; n < 400; n++) begin
            clr();
            for (int i = 0; i < LANES; i++) begin
                s_cond[i] = ($urandom_range(1, 0) != 0) ? 4'd14 : 4'($urandom_range(15, 0));
                s_fw[i]   = FGROUPS'($urandom);
                s_alu[i]  = 4'($urandom);
            end
            s_valid  = LANES'($urandom);
            s_pcsrc  = LANES'($urandom) & LANES'($urandom);
            s_branch = LANES'($urandom) & LANES'($urandom);
            s_regw   = LANES'($urandom);
            s_memw   = LANES'($urandom);
            s_nowr   = LANES'($urandom) & LANES'($urandom);
            for (int i = 0; i < LANES; i++) s_defer[i] = ($urandom_range(7, 0) == 0);
            s_late_valid = ($urandom_range(3, 0) == 0);
            s_late       = 4'($urandom);
            s_flush      = ($urandom_range(9, 0) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
